// File: rtl/mempipe_arb_if.sv
// Request packet type and the mm0/mm1 arbiter bus. The arbiter takes the slave
// side; the load/store/fill queues and the L1 pipe sit on the master side.
package mempipe_arb_pkg;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] op;
      logic [9:0] addr;
   } t_mempipe_arb;
endpackage

interface mempipe_arb_if #(parameter int SET_W = 6);
   import mempipe_arb_pkg::*;

   logic             pipe_stall_mm0;
   logic             ld_req_mm0;
   logic             st_req_mm0;
   logic             fl_req_mm0;
   t_mempipe_arb     ld_req_pkt_mm0;
   t_mempipe_arb     st_req_pkt_mm0;
   t_mempipe_arb     fl_req_pkt_mm0;
   logic [SET_W-1:0] ld_set_mm0;
   logic [SET_W-1:0] st_set_mm0;
   logic [SET_W-1:0] fl_set_mm0;
   logic             ld_gnt_mm0;
   logic             st_gnt_mm0;
   logic             fl_gnt_mm0;
   logic             req_valid_mm1;
   t_mempipe_arb     req_pkt_mm1;
   logic [SET_W-1:0] set_addr_mm1;

   modport slave (
      input  pipe_stall_mm0, ld_req_mm0, st_req_mm0, fl_req_mm0,
             ld_req_pkt_mm0, st_req_pkt_mm0, fl_req_pkt_mm0,
             ld_set_mm0, st_set_mm0, fl_set_mm0,
      output ld_gnt_mm0, st_gnt_mm0, fl_gnt_mm0,
             req_valid_mm1, req_pkt_mm1, set_addr_mm1
   );

   modport master (
      output pipe_stall_mm0, ld_req_mm0, st_req_mm0, fl_req_mm0,
             ld_req_pkt_mm0, st_req_pkt_mm0, fl_req_pkt_mm0,
             ld_set_mm0, st_set_mm0, fl_set_mm0,
      input  ld_gnt_mm0, st_gnt_mm0, fl_gnt_mm0,
             req_valid_mm1, req_pkt_mm1, set_addr_mm1
   );
endinterface

// File: rtl/mempipe_arb.sv
// Mem pipeline arbiter: picks one of load/store/fill in mm0 and registers the
// winner into mm1. Fill-first, load/store round-robin, starvation override.
module mempipe_arb
   import mempipe_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int HAZ_DEPTH    = 4,
   parameter int SET_W        = 6
) (
   input  logic         clk,
   input  logic         reset,
   mempipe_arb_if.slave bus
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [HAZ_DEPTH-1:0]            haz_vld;
   logic [HAZ_DEPTH-1:0][SET_W-1:0] haz_set;
   logic [3:0] ld_cnt, st_cnt, fl_cnt;
   logic       rr;
   logic       ld_haz, st_haz;
   logic       ld_ok, st_ok, fl_ok;
   logic       ld_gnt, st_gnt, fl_gnt, any_gnt;
   t_mempipe_arb     win_pkt;
   logic [SET_W-1:0] win_set;

   // A fill granted this cycle is not in the window yet; it wins anyway.
   always_comb begin
      ld_haz = 1'b0;
      st_haz = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (haz_vld[i] && haz_set[i] == bus.ld_set_mm0) ld_haz = 1'b1;
         if (haz_vld[i] && haz_set[i] == bus.st_set_mm0) st_haz = 1'b1;
      end
   end

   assign ld_ok = bus.ld_req_mm0 && !bus.pipe_stall_mm0 && !ld_haz;
   assign st_ok = bus.st_req_mm0 && !bus.pipe_stall_mm0 && !st_haz;
   assign fl_ok = bus.fl_req_mm0 && !bus.pipe_stall_mm0;

   always_comb begin
      ld_gnt = 1'b0;
      st_gnt = 1'b0;
      fl_gnt = 1'b0;
      if (!reset) begin
         if (fl_ok && fl_cnt == LIMIT)      fl_gnt = 1'b1;
         else if (st_ok && st_cnt == LIMIT) st_gnt = 1'b1;
         else if (ld_ok && ld_cnt == LIMIT) ld_gnt = 1'b1;
         else if (fl_ok)                    fl_gnt = 1'b1;
         else if (ld_ok && st_ok) begin
            if (rr) st_gnt = 1'b1;
            else    ld_gnt = 1'b1;
         end
         else if (ld_ok)                    ld_gnt = 1'b1;
         else if (st_ok)                    st_gnt = 1'b1;
      end
   end

   assign any_gnt = ld_gnt | st_gnt | fl_gnt;

   always_comb begin
      win_pkt = bus.ld_req_pkt_mm0;
      win_set = bus.ld_set_mm0;
      if (fl_gnt) begin
         win_pkt = bus.fl_req_pkt_mm0;
         win_set = bus.fl_set_mm0;
      end else if (st_gnt) begin
         win_pkt = bus.st_req_pkt_mm0;
         win_set = bus.st_set_mm0;
      end
   end

   assign bus.ld_gnt_mm0 = ld_gnt;
   assign bus.st_gnt_mm0 = st_gnt;
   assign bus.fl_gnt_mm0 = fl_gnt;

   // Counts every denied cycle (stall and hazard too), saturating at the limit.
   function automatic logic [3:0] nxt_cnt(logic req, logic gnt, logic [3:0] cnt);
      if (!req || gnt)  return 4'd0;
      if (cnt == LIMIT) return cnt;
      return cnt + 4'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         haz_vld           <= '0;
         haz_set           <= '0;
         ld_cnt            <= '0;
         st_cnt            <= '0;
         fl_cnt            <= '0;
         rr                <= 1'b0;
         bus.req_valid_mm1 <= 1'b0;
         bus.req_pkt_mm1   <= '0;
         bus.set_addr_mm1  <= '0;
      end else begin
         for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
            haz_vld[i] <= haz_vld[i-1];
            haz_set[i] <= haz_set[i-1];
         end
         haz_vld[0] <= fl_gnt;
         haz_set[0] <= bus.fl_set_mm0;
         ld_cnt <= nxt_cnt(bus.ld_req_mm0, ld_gnt, ld_cnt);
         st_cnt <= nxt_cnt(bus.st_req_mm0, st_gnt, st_cnt);
         fl_cnt <= nxt_cnt(bus.fl_req_mm0, fl_gnt, fl_cnt);
         if (ld_gnt)      rr <= 1'b1;
         else if (st_gnt) rr <= 1'b0;
         bus.req_valid_mm1 <= any_gnt;
         if (any_gnt) begin
            bus.req_pkt_mm1  <= win_pkt;
            bus.set_addr_mm1 <= win_set;
         end
      end
   end
endmodule
